// File: rtl/cva6_shim_pkg.sv
// Shared types and constants for the CVA6-style LSU shim: decode constants,
// the control FSM encoding and the store-buffer entry layout.
package cva6_shim_pkg;

  localparam int DEFAULT_SB_DEPTH  = 4;
  localparam int DEFAULT_MEM_WORDS = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ST_ISSUE,
    LD_WAIT
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/cva6_shim_store_buffer.sv
// In-order store buffer: FIFO of pending stores plus a parallel word-address
// compare so a waiting load can tell whether any buffered store aliases it.
module cva6_shim_store_buffer
  import cva6_shim_pkg::*;
#(
  parameter int DEPTH = DEFAULT_SB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_addr,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [4:0]  head_idx,
  output logic [31:0] head_data,
  output logic        full,
  output logic        empty,
  input  logic [9:0]  query_word,
  output logic        conflict
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

  sb_entry_t   entries [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_idx  = entries[head].addr[6:2];
  assign head_data = entries[head].data;

  // A simultaneous pop and push on a full buffer hit the same slot; the push
  // is written last so the new entry stays valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_pop) begin
        entries[head].valid <= 1'b0;
        head <= next_ptr(head);
      end
      if (do_push) begin
        entries[tail] <= '{valid: 1'b1, addr: push_addr, data: push_data};
        tail <= next_ptr(tail);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && (entries[i].addr[11:2] == query_word)) conflict = 1'b1;
    end
  end

endmodule

// File: rtl/cva6_lsu_processor_shim.sv
// Minimal in-order RV32 shim executing ADDI/LW/SW; stores retire through a
// store buffer and loads stall while any buffered store aliases their word.
module cva6_lsu_processor_shim
  import cva6_shim_pkg::*;
#(
  parameter int SB_DEPTH  = DEFAULT_SB_DEPTH,
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        store_mem_resp_i,
  input  logic        load_mem_resp_i
`ifdef EXPOSE_STATE
  ,
  output logic [1023:0]            regfile_o,
  output logic [32*MEM_WORDS-1:0]  mem_o
`endif
);

  state_t      state;
  logic [31:0] regs [32];
  logic [31:0] mem  [MEM_WORDS];
  logic [9:0]  ld_word;
  logic [4:0]  ld_idx, ld_rd;
  logic [31:0] st_addr, st_data;

  logic        sb_full, sb_empty, sb_conflict;
  logic [4:0]  sb_head_idx;
  logic [31:0] sb_head_data;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, eff_addr;
  logic        is_addi, is_lw, is_sw, accept;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign rd      = instr_i[11:7];
  assign rs1     = instr_i[19:15];
  assign rs2     = instr_i[24:20];
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign imm_i   = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign is_addi = (opcode == OPC_OP_IMM) && (funct3 == F3_ADDI);
  assign is_lw   = (opcode == OPC_LOAD)   && (funct3 == F3_LW);
  assign is_sw   = (opcode == OPC_STORE)  && (funct3 == F3_SW);
  assign eff_addr = rs1_val + (is_sw ? imm_s : imm_i);

  assign instr_ready_o = (state == IDLE) && !sb_full && !rst_i;
  assign accept        = instr_valid_i && instr_ready_o;

  cva6_shim_store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (state == ST_ISSUE),
    .push_addr  (st_addr),
    .push_data  (st_data),
    .pop        (store_mem_resp_i),
    .head_idx   (sb_head_idx),
    .head_data  (sb_head_data),
    .full       (sb_full),
    .empty      (sb_empty),
    .query_word (ld_word),
    .conflict   (sb_conflict)
  );

  // x0 is never written, so it keeps reading zero after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      ld_word <= '0;
      ld_idx  <= '0;
      ld_rd   <= '0;
      st_addr <= '0;
      st_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_addi && (rd != 5'd0)) regs[rd] <= rs1_val + imm_i;
            if (is_sw) begin
              st_addr <= eff_addr;
              st_data <= rs2_val;
              state   <= ST_ISSUE;
            end
            if (is_lw) begin
              ld_word <= eff_addr[11:2];
              ld_idx  <= eff_addr[6:2];
              ld_rd   <= rd;
              state   <= LD_WAIT;
            end
          end
        end
        ST_ISSUE: state <= IDLE;
        LD_WAIT: begin
          if (load_mem_resp_i && !sb_conflict) begin
            if (ld_rd != 5'd0) regs[ld_rd] <= mem[ld_idx];
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store drain runs independently of the FSM whenever memory accepts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (store_mem_resp_i && !sb_empty) begin
      mem[sb_head_idx] <= sb_head_data;
    end
  end

`ifdef EXPOSE_STATE
  for (genvar g = 0; g < 32; g++) begin : g_rf
    assign regfile_o[32*g +: 32] = regs[g];
  end
  for (genvar g = 0; g < MEM_WORDS; g++) begin : g_mem
    assign mem_o[32*g +: 32] = mem[g];
  end
`endif

endmodule

// File: tb/tb_cva6_lsu_processor_shim.sv
// Scoreboard bench for cva6_lsu_processor_shim: a queue-based architectural
// model predicts ready per cycle and register/memory contents at checkpoints.
module tb_cva6_lsu_processor_shim;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic        store_mem_resp_i = 1'b0;
  logic        load_mem_resp_i = 1'b0;
  logic [1023:0] rf_flat, mem_flat;

  always #5 clk = ~clk;

  cva6_lsu_processor_shim dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .instr_i          (instr_i),
    .instr_valid_i    (instr_valid_i),
    .instr_ready_o    (instr_ready_o),
    .store_mem_resp_i (store_mem_resp_i),
    .load_mem_resp_i  (load_mem_resp_i)
`ifdef EXPOSE_STATE
    ,
    .regfile_o        (rf_flat),
    .mem_o            (mem_flat)
`endif
  );

`ifndef EXPOSE_STATE
  for (genvar g = 0; g < 32; g++) begin : g_peek
    assign rf_flat[32*g +: 32]  = dut.regs[g];
    assign mem_flat[32*g +: 32] = dut.mem[g];
  end
`endif

  typedef struct { logic [31:0] addr; logic [31:0] data; } store_t;
  typedef struct { bit is_mem; int idx; logic [31:0] val; } snap_t;

  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [32];
  store_t      m_sbq [$];
  bit          pend_store, pend_load;
  store_t      pend_st;
  logic [31:0] m_ld_addr;
  logic [4:0]  m_ld_rd;

  bit    exp_ready_q [$];
  snap_t snap_q [$];
  int    checks = 0;
  int    failures = 0;
  int    cycle = 0;

  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    logic [11:0] i12 = 12'(imm);
    return {i12, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lw(input int rd, input int rs1, input int imm);
    logic [11:0] i12 = 12'(imm);
    return {i12, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_sw(input int rs2, input int rs1, input int imm);
    logic [11:0] i12 = 12'(imm);
    return {i12[11:5], 5'(rs2), 5'(rs1), 3'b010, i12[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_mem[i]  = '0;
    end
    m_sbq.delete();
    pend_store = 0;
    pend_load  = 0;
  endfunction

  function automatic bit model_ready();
    return !rst_i && !pend_store && !pend_load && (m_sbq.size() < 4);
  endfunction

  // Architectural effect of one clock edge, given the inputs held across it.
  function automatic void model_step(input bit rdy, input bit v, input logic [31:0] ins,
                                     input bit s, input bit l);
    bit aliased = 0;
    store_t head;
    logic [31:0] a;
    if (rst_i) return;
    foreach (m_sbq[i]) if (m_sbq[i].addr[11:2] == m_ld_addr[11:2]) aliased = 1;
    if (pend_load && l && !aliased) begin
      if (m_ld_rd != 0) m_regs[m_ld_rd] = m_mem[m_ld_addr[6:2]];
      pend_load = 0;
    end
    if (s && m_sbq.size() > 0) begin
      head = m_sbq.pop_front();
      m_mem[head.addr[6:2]] = head.data;
    end
    if (pend_store) begin
      m_sbq.push_back(pend_st);
      pend_store = 0;
    end
    if (rdy && v) begin
      a = m_regs[ins[19:15]];
      if (ins[6:0] == 7'b0010011 && ins[14:12] == 3'b000) begin
        if (ins[11:7] != 0) m_regs[ins[11:7]] = a + sext12(ins[31:20]);
      end else if (ins[6:0] == 7'b0100011 && ins[14:12] == 3'b010) begin
        pend_st.addr = a + sext12({ins[31:25], ins[11:7]});
        pend_st.data = m_regs[ins[24:20]];
        pend_store = 1;
      end else if (ins[6:0] == 7'b0000011 && ins[14:12] == 3'b010) begin
        m_ld_addr = a + sext12(ins[31:20]);
        m_ld_rd   = ins[11:7];
        pend_load = 1;
      end
    end
  endfunction

  // Called just after a rising edge: drive this cycle's inputs, queue the
  // expected ready level, then advance the model across the next edge.
  task automatic applyStimulus(input bit v, input logic [31:0] ins, input bit s,
                               input bit l, input bit r);
    bit rdy;
    rst_i = r;
    if (r) model_reset();
    instr_valid_i    = v;
    instr_i          = ins;
    store_mem_resp_i = s;
    load_mem_resp_i  = l;
    rdy = model_ready();
    exp_ready_q.push_back(rdy);
    @(posedge clk);
    model_step(rdy, v, ins, s, l);
    cycle++;
    #1;
  endtask

  task automatic idle(input int n, input bit s, input bit l);
    for (int i = 0; i < n; i++) applyStimulus(0, 32'd0, s, l, 0);
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 32; i++) begin
      snap_q.push_back('{is_mem: 0, idx: i, val: m_regs[i]});
      snap_q.push_back('{is_mem: 1, idx: i, val: m_mem[i]});
    end
  endtask

  initial begin : monitor
    bit    e;
    snap_t sn;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      if (exp_ready_q.size() > 0) begin
        e = exp_ready_q.pop_front();
        checks++;
        if (instr_ready_o !== e) begin
          failures++;
          $display("[TB] FAIL ready cycle=%0d got=%0b exp=%0b", cycle, instr_ready_o, e);
        end
      end
      while (snap_q.size() > 0) begin
        sn  = snap_q.pop_front();
        got = sn.is_mem ? mem_flat[32*sn.idx +: 32] : rf_flat[32*sn.idx +: 32];
        checks++;
        if (got !== sn.val) begin
          failures++;
          $display("[TB] FAIL %s[%0d] cycle=%0d got=%h exp=%h",
                   sn.is_mem ? "mem" : "reg", sn.idx, cycle, got, sn.val);
        end
      end
    end
  end

  initial begin : driver
    int kind, rd, rs, imm;
    logic [31:0] ins;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0, 32'd0, 0, 0, 1);
    idle(2, 0, 0);
    checkOutput();

    applyStimulus(1, 32'h00500093, 0, 0, 0);
    idle(1, 0, 0);
    applyStimulus(1, enc_addi(0, 0, 7), 0, 0, 0);
    idle(1, 0, 0);
    checkOutput();

    applyStimulus(1, enc_sw(1, 2, 0), 1, 0, 0);
    idle(2, 1, 0);
    checkOutput();

    applyStimulus(1, enc_sw(1, 0, 8), 1, 0, 0);
    idle(3, 1, 0);
    applyStimulus(1, enc_addi(4, 0, 8), 0, 0, 0);
    applyStimulus(1, enc_lw(3, 4, 0), 0, 1, 0);
    idle(2, 0, 1);
    checkOutput();

    applyStimulus(1, enc_sw(1, 0, 0), 0, 0, 0);
    idle(1, 0, 0);
    applyStimulus(1, enc_lw(5, 0, 0), 0, 1, 0);
    idle(20, 0, 1);
    idle(3, 1, 1);
    checkOutput();

    applyStimulus(1, enc_sw(1, 0, 0), 0, 0, 0);
    idle(1, 0, 0);
    applyStimulus(1, enc_lw(6, 0, 4), 0, 1, 0);
    idle(2, 0, 1);
    idle(3, 1, 0);
    checkOutput();

    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, enc_sw(1, 0, 16 + 4 * k), 0, 0, 0);
      idle(1, 0, 0);
    end
    idle(4, 0, 0);
    applyStimulus(0, 32'd0, 1, 0, 0);
    applyStimulus(1, enc_sw(4, 0, 40), 0, 0, 0);
    idle(8, 1, 0);
    checkOutput();

    applyStimulus(1, enc_sw(1, 0, 0), 0, 0, 0);
    idle(1, 0, 0);
    applyStimulus(1, enc_lw(7, 0, 0), 0, 1, 0);
    idle(3, 0, 1);
    applyStimulus(0, 32'd0, 0, 1, 1);
    checkOutput();
    idle(2, 0, 0);
    checkOutput();

    for (int n = 0; n < 3000; n++) begin
      kind = $urandom_range(0, 5);
      rd   = $urandom_range(0, 31);
      rs   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 31);
      imm  = 4 * $urandom_range(0, 31);
      case (kind)
        0, 1:    ins = enc_addi(rd, $urandom_range(0, 31), $urandom_range(0, 4095));
        2:       ins = enc_lw(rd, rs, imm);
        3, 4:    ins = enc_sw($urandom_range(0, 31), rs, imm);
        default: ins = {$urandom_range(0, 32'h1ffffff), 7'b0110011};
      endcase
      applyStimulus($urandom_range(0, 3) != 0, ins, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 499) == 0);
      if (n % 100 == 99) checkOutput();
    end
    idle(10, 1, 1);
    checkOutput();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/cva6_lsu_processor_shim.md
Name: cva6_lsu_processor_shim

Overview:
- Minimal in-order RV32 execution shim wrapping a CVA6-style load/store unit model.
- Accepts one instruction per valid/ready handshake and executes LW, SW and ADDI against an internal 32x32 register file and 32-word data memory.
- Stores retire through a store buffer; loads stall on store-buffer address conflicts.
- Used as the DUT in two-copy timing-leakage (non-interference) checks on instr_ready_o.

Parameters:
- SB_DEPTH, 4, store-buffer entries.
- MEM_WORDS, 32, data-memory words (index = address[6:2]).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_i  in  32  RV32 instruction word.
- instr_valid_i  in  1  instruction offered.
- instr_ready_o  out  1  shim can accept an instruction this cycle.
- store_mem_resp_i  in  1  memory accepts the oldest store-buffer entry this cycle.
- load_mem_resp_i  in  1  memory returns data for the pending load this cycle.
- regfile_o  out  1024  present only when macro EXPOSE_STATE is defined; register i at bits [32i+31:32i].
- mem_o  out  1024  present only under EXPOSE_STATE; word i at bits [32i+31:32i].

Behaviour:
- Reset (async, active-high):
  - Registers and memory cleared to 0; store buffer emptied; FSM to IDLE.
  - instr_ready_o = 0 while rst_i is high.
- Handshake: an instruction is accepted on a rising edge where instr_valid_i && instr_ready_o. instr_i is sampled only then.
- Decode:
  - opcode 0010011, funct3 000: ADDI.
  - opcode 0000011, funct3 010: LW.
  - opcode 0100011, funct3 010: SW.
  - Anything else: accepted and treated as NOP.
  - x0 reads 0; writes to x0 are discarded.
- ADDI: rd <= rs1 + sext(imm[11:0]), written at the accept edge. FSM stays IDLE; ready stays high.
- SW:
  - Accept edge: addr = rs1 + sext({instr[31:25], instr[11:7]}); data = rs2. Move to ST_ISSUE.
  - ST_ISSUE (1 cycle, ready=0): push {addr, data} into the store buffer, then return to IDLE.
- LW:
  - Accept edge: latch addr = rs1 + sext(instr[31:20]) and rd. Move to LD_WAIT with ready=0.
  - LD_WAIT: the load completes on the first edge where load_mem_resp_i=1 and no valid store-buffer entry has addr[11:2] equal to the load addr[11:2].
  - On completion: rd <= mem[addr[6:2]]; return to IDLE, so ready is 1 next cycle. Minimum load latency is 1 cycle after accept.
  - While a conflict exists, load_mem_resp_i is ignored. The load waits until the conflicting entries drain.
  - No store-to-load forwarding.
- Store buffer:
  - FIFO of SB_DEPTH entries.
  - When store_mem_resp_i=1 and the buffer is non-empty, the head entry writes mem[addr[6:2]] and pops.
  - Push and pop in the same cycle are both honoured.
  - Drain continues in every FSM state.
- instr_ready_o = (state==IDLE) && !(store buffer full) && !rst_i.
  - A full buffer blocks all instructions until a pop.
  - With store_mem_resp_i held 0, a load that conflicts with a buffered store stalls forever. This is the intended data-dependent timing behaviour.
- Address bits above [11:2] are ignored for conflicts. Memory index uses only [6:2]. The low two address bits are ignored (no misalignment trap).
- Reset mid-operation aborts any pending load and discards buffered stores.

Decomposition:
- Shared package cva6_shim_pkg:
  - opcode/funct3 constants;
  - FSM enum {IDLE, ST_ISSUE, LD_WAIT};
  - store-buffer entry struct {valid, addr[31:0], data[31:0]};
  - SB_DEPTH default.
- One sub-module: cva6_shim_store_buffer.
  - FIFO with push/pop and full/empty.
  - Parallel conflict-compare output against a query address (bits [11:2]).

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093) -> ready stays 1; regfile_o x1=5 next cycle. Writing x0 leaves it 0.
- SW x1,0(x2) with x1=5, x2=0, store_mem_resp_i=1 -> ready low 1 cycle after accept; mem word 0 = 5 two cycles after accept.
- LW x3,0(x4) with x4=8, load_mem_resp_i=1, empty buffer -> ready low exactly 1 cycle; x3 = mem[2].
- SW to address 0, then LW from 0 with store_mem_resp_i=0, load_mem_resp_i=1 -> ready stays 0 indefinitely.
  - Same test with LW from 0x4 instead -> no conflict; load completes in 1 cycle.
- Five SWs with store_mem_resp_i=0 -> after 4 pushes ready stays 0. Raising store_mem_resp_i for 1 cycle re-enables ready.
- Assert rst_i during LD_WAIT -> ready 0 immediately; after release, registers/memory are 0, buffer empty, ready = 1.
